pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives enable/flush controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three conditions:
- load-use hazards (one bubble)
- branch/jump redirects resolved in EX (two-instruction flush)
- multi-cycle data-memory waits (full freeze with WB bubble)

Also provides a halt/drain sequence for debug and low-power entry.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/load_use_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer:
// controller state encoding, the x0 register index and stage indices
// used to address per-stage enable/flush vectors.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Stage indices. A pipeline register is indexed by the stage it feeds,
  // so index STG_IF addresses the PC register.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the datapath and the
// stall/flush controls plus status/perf outputs back to it.
// slave  = the hazard controller, master = the datapath side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_MemRead;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_req;
  logic             dmem_ready;
  logic             halt_req;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
           ex_redirect, mem_req, dmem_ready, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, mem_timeout, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_MemRead, ex_rd,
           ex_redirect, mem_req, dmem_ready, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, mem_timeout, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags when the ID instruction
// reads a register that the load currently in EX will write. Kept
// separate so the forwarding unit can reuse it.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  output logic       o_lu_hz
);

  // A load to x0 never produces a value, so it cannot create a hazard.
  always_comb begin
    o_lu_hz = i_ex_mem_read && (i_ex_rd != REG_X0) &&
              ((i_id_use_rs1 && (i_ex_rd == i_id_rs1)) ||
               (i_id_use_rs2 && (i_ex_rd == i_id_rs2)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves
// load-use bubbles, EX redirects, data-memory waits (with a sticky
// timeout flag) and a halt/drain sequence.
// Optional feature macro: PIPE_HAZARD_PERF_CNT_EN enables the stall and
// redirect-flush performance counters; otherwise both read constant 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 256,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [DRN_W-1:0]   r_drain_cnt;
  logic               r_mem_timeout;

  logic               w_lu_hz;
  logic               w_mem_stall;
  logic [STG_WB:STG_IF] w_en;
  logic [STG_WB:STG_ID] w_flush;
  logic               w_halted;

  load_use_detect u_lu (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_use_rs1  (bus.id_use_rs1),
    .i_id_use_rs2  (bus.id_use_rs2),
    .i_ex_mem_read (bus.ex_MemRead),
    .i_ex_rd       (bus.ex_rd),
    .o_lu_hz       (w_lu_hz)
  );

  assign w_mem_stall = bus.mem_req && !bus.dmem_ready;

  // Next state and same-cycle stage controls; reset forces every stage
  // to load a bubble and holds the PC.
  always_comb begin
    w_state_nxt = r_state;
    w_en        = '1;
    w_flush     = '0;
    w_halted    = 1'b0;

    unique case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_stall) begin
          w_en[STG_IF]    = 1'b0;
          w_en[STG_ID]    = 1'b0;
          w_en[STG_EX]    = 1'b0;
          w_en[STG_MEM]   = 1'b0;
          w_flush[STG_WB] = 1'b1;
          w_state_nxt     = MEM_WAIT;
        end else if (bus.ex_redirect) begin
          // The ID instruction is squashed, so any load-use hazard it
          // carries is moot.
          w_flush[STG_ID] = 1'b1;
          w_flush[STG_EX] = 1'b1;
          w_state_nxt     = RUN;
        end else if (w_lu_hz) begin
          w_en[STG_IF]    = 1'b0;
          w_en[STG_ID]    = 1'b0;
          w_flush[STG_EX] = 1'b1;
          w_state_nxt     = RUN;
        end else if (bus.halt_req) begin
          w_state_nxt     = DRAIN;
        end else begin
          w_state_nxt     = RUN;
        end
      end

      DRAIN: begin
        if (w_mem_stall) begin
          w_en[STG_IF]    = 1'b0;
          w_en[STG_ID]    = 1'b0;
          w_en[STG_EX]    = 1'b0;
          w_en[STG_MEM]   = 1'b0;
          w_flush[STG_WB] = 1'b1;
        end else begin
          w_en[STG_IF]    = bus.ex_redirect;
          w_flush[STG_ID] = 1'b1;
          if (r_drain_cnt == DRAIN_LAST) begin
            w_state_nxt = HALTED;
          end
        end
      end

      HALTED: begin
        w_en     = '0;
        w_halted = 1'b1;
        if (!bus.halt_req) begin
          w_state_nxt = RUN;
        end
      end

      default: w_state_nxt = RUN;
    endcase

    if (rst) begin
      w_en        = '0;
      w_flush     = '1;
      w_halted    = 1'b0;
      w_state_nxt = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-wait counter and sticky timeout flag; the counter saturates
  // at the timeout threshold and clears outside a stalled MEM_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if ((r_state == MEM_WAIT) && w_mem_stall) begin
      if (r_wait_cnt == WAIT_LAST) begin
        r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Drain progress counter; frozen by memory stalls, cleared on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN) begin
      if (!w_mem_stall) begin
        if (r_drain_cnt == DRAIN_LAST) begin
          r_drain_cnt <= '0;
        end else begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
        end
      end
    end else begin
      r_drain_cnt <= '0;
    end
  end

  assign bus.pc_en       = w_en[STG_IF];
  assign bus.ifid_en     = w_en[STG_ID];
  assign bus.idex_en     = w_en[STG_EX];
  assign bus.exmem_en    = w_en[STG_MEM];
  assign bus.memwb_en    = w_en[STG_WB];
  assign bus.ifid_flush  = w_flush[STG_ID];
  assign bus.idex_flush  = w_flush[STG_EX];
  assign bus.exmem_flush = w_flush[STG_MEM];
  assign bus.memwb_flush = w_flush[STG_WB];
  assign bus.halted      = w_halted;
  assign bus.mem_timeout = r_mem_timeout;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall_cnt;
  logic [CNT_W-1:0] r_perf_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = (r_state != HALTED) && !w_en[STG_IF];
  assign w_flush_evt = (r_state != HALTED) && bus.ex_redirect && !w_mem_stall;

  // Free-running event counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall_evt) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
      end
      if (w_flush_evt) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`else
  assign bus.perf_stall_cnt = {CNT_W{1'b0}};
  assign bus.perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (DRAIN_CYCLES=4, MEM_TIMEOUT=8).
// Control outputs are packed as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//  ifid_flush, idex_flush, exmem_flush, memwb_flush, halted}.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  localparam logic [9:0] CTL_RUN   = 10'b11111_0000_0;
  localparam logic [9:0] CTL_RST   = 10'b00000_1111_0;
  localparam logic [9:0] CTL_LU    = 10'b00111_0100_0;
  localparam logic [9:0] CTL_REDIR = 10'b11111_1100_0;
  localparam logic [9:0] CTL_DRAIN = 10'b01111_1000_0;
  localparam logic [9:0] CTL_HALT  = 10'b00000_0000_1;
  // Freeze: memwb_en is a don't-care because memwb_flush dominates.
  localparam logic [9:0] FRZ_MASK  = 10'b11110_1111_1;
  localparam logic [9:0] CTL_FRZ   = 10'b00000_0001_0;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(
    .DRAIN_CYCLES (4),
    .MEM_TIMEOUT  (8),
    .CNT_W        (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                bus.halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_MemRead  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.mem_req     = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.halt_req    = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RST) begin
      n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RST);
    end
    n_vec++;
    if (bus.mem_timeout !== 1'b0 || bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_regs got=%b/%0d/%0d exp=0/0/0",
                        bus.mem_timeout, bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL post_reset_run got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_LU) begin
      n_err++; $display("FAIL lu_rs1_stall got=%b exp=%b", ctl, CTL_LU);
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL lu_single_bubble got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL lu_x0_nostall got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    idle();
    bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
    bus.id_rs1 = 5'd7;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_LU) begin
      n_err++; $display("FAIL lu_rs2_stall got=%b exp=%b", ctl, CTL_LU);
    end
    tick();
    bus.id_use_rs2 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL lu_unused_src got=%b exp=%b", ctl, CTL_RUN);
    end
    bus.id_use_rs2 = 1'b1; bus.ex_MemRead = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL lu_not_load got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    idle();
  endtask

  task automatic test_redirect_hazard();
    apply_reset();
    bus.ex_redirect = 1'b1;
    bus.ex_MemRead = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_REDIR) begin
      n_err++; $display("FAIL redirect_over_lu got=%b exp=%b", ctl, CTL_REDIR);
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL redirect_after got=%b exp=%b", ctl, CTL_RUN);
    end
    n_vec++;
    if (bus.perf_flush_cnt !== 32'(PERF_ON) || bus.perf_stall_cnt !== 32'd0) begin
      n_err++; $display("FAIL redirect_perf got=%0d/%0d exp=%0d/0",
                        bus.perf_flush_cnt, bus.perf_stall_cnt, PERF_ON);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ((ctl & FRZ_MASK) !== CTL_FRZ) begin
        n_err++; $display("FAIL mem_freeze[%0d] got=%b exp=%b", i, ctl & FRZ_MASK, CTL_FRZ);
      end
      tick();
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL mem_ready_cycle got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (bus.perf_stall_cnt !== 32'(3 * PERF_ON) || bus.mem_timeout !== 1'b0 || ctl !== CTL_RUN) begin
      n_err++; $display("FAIL mem_after got=%0d/%b/%b exp=%0d/0/%b",
                        bus.perf_stall_cnt, bus.mem_timeout, ctl, 3 * PERF_ON, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    // One RUN stall cycle, then eight MEM_WAIT cycles.
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 8) begin
        n_vec++;
        if (bus.mem_timeout !== 1'b0) begin
          n_err++; $display("FAIL timeout_early got=%b exp=0", bus.mem_timeout);
        end
      end
    end
    n_vec++;
    if (bus.mem_timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout_set got=%b exp=1", bus.mem_timeout);
    end
    @(negedge clk);
    n_vec++;
    if ((ctl & FRZ_MASK) !== CTL_FRZ) begin
      n_err++; $display("FAIL timeout_still_wait got=%b exp=%b", ctl & FRZ_MASK, CTL_FRZ);
    end
    bus.dmem_ready = 1'b1;
    tick();
    idle();
    tick();
    tick();
    n_vec++;
    if (bus.mem_timeout !== 1'b1 || ctl !== CTL_RUN) begin
      n_err++; $display("FAIL timeout_sticky got=%b/%b exp=1/%b", bus.mem_timeout, ctl, CTL_RUN);
    end
    apply_reset();
    n_vec++;
    if (bus.mem_timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_cleared got=%b exp=0", bus.mem_timeout);
    end
  endtask

  task automatic run_full_drain(input string tag);
    bus.halt_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL %s_accept got=%b exp=%b", tag, ctl, CTL_RUN);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (ctl !== CTL_DRAIN) begin
        n_err++; $display("FAIL %s_drain[%0d] got=%b exp=%b", tag, i, ctl, CTL_DRAIN);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_HALT) begin
      n_err++; $display("FAIL %s_halted got=%b exp=%b", tag, ctl, CTL_HALT);
    end
    bus.halt_req = 1'b0;
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL %s_resume got=%b exp=%b", tag, ctl, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_halt();
    idle();
    run_full_drain("halt");
  endtask

  task automatic test_drain_stall();
    idle();
    bus.halt_req = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_DRAIN) begin
      n_err++; $display("FAIL ds_drain0 got=%b exp=%b", ctl, CTL_DRAIN);
    end
    tick();
    bus.mem_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ((ctl & FRZ_MASK) !== CTL_FRZ) begin
      n_err++; $display("FAIL ds_freeze got=%b exp=%b", ctl & FRZ_MASK, CTL_FRZ);
    end
    tick();
    // halt_req dropped mid-drain: the remaining three drain cycles still run.
    bus.mem_req = 1'b0;
    bus.halt_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (ctl !== CTL_DRAIN) begin
        n_err++; $display("FAIL ds_drain[%0d] got=%b exp=%b", i, ctl, CTL_DRAIN);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_HALT) begin
      n_err++; $display("FAIL ds_halted got=%b exp=%b", ctl, CTL_HALT);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN) begin
      n_err++; $display("FAIL ds_exit got=%b exp=%b", ctl, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    idle();
    bus.halt_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RST) begin
      n_err++; $display("FAIL rmd_in_reset got=%b exp=%b", ctl, CTL_RST);
    end
    tick();
    rst = 1'b0;
    bus.halt_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ctl !== CTL_RUN || bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0
        || bus.mem_timeout !== 1'b0) begin
      n_err++; $display("FAIL rmd_release got=%b/%0d/%0d/%b exp=%b/0/0/0", ctl,
                        bus.perf_stall_cnt, bus.perf_flush_cnt, bus.mem_timeout, CTL_RUN);
    end
    tick();
    run_full_drain("rmd");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_hazard();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_drain_stall();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
